// File: rtl/data_mem_port_if.sv
// Request/response bus between the RV32I core and the data memory port.
// Latency: none, wires only; the port decides when a request is accepted.
// Backpressure: req_ready gates requests; the response pulse cannot be stalled.
interface data_mem_port_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    // Core side: issues requests, consumes responses.
    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error
    );

    // Memory port side: accepts requests, produces responses.
    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_error
    );
endinterface

// File: rtl/data_mem_port.sv
// Load/store formatter between the RV32I core and a word-addressed BRAM (optional MISALIGN_TRAP_EN traps misaligned H/W).
// Latency: store rsp 2 cycles after accept, load 3, illegal/misaligned 1; one-cycle rsp_valid pulse.
// Backpressure: req_ready only in IDLE, so one request in flight; response has no backpressure.
module data_mem_port #(
    parameter int MEM_ADDR_BITS = 14
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    data_mem_port_if.slave           bus,
    output logic [MEM_ADDR_BITS-1:0] mem_addr_o,
    output logic [31:0]              mem_wdata_o,
    output logic [3:0]               mem_wmask_o,
    output logic                     mem_rstrb_o,
    input  logic [31:0]              mem_rdata_i
);

    localparam int AW = MEM_ADDR_BITS + 2;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WRITE = 3'd1;
    localparam logic [2:0] ST_READ  = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    logic [2:0]    state_q,  state_d;
    logic [AW-1:0] addr_q,   addr_d;
    logic [2:0]    funct3_q, funct3_d;
    logic [31:0]   wdata_q,  wdata_d;
    logic [31:0]   rdata_q,  rdata_d;
    logic          error_q,  error_d;

    logic          req_illegal;
    logic          req_misalign;
    logic [31:0]   load_data;
    logic [7:0]    load_byte;
    logic [15:0]   load_half;

    // Address bits above the BRAM span are dropped so accesses wrap.
    logic unused_addr_hi;
    assign unused_addr_hi = |bus.req_addr[31:AW];

    // Classify the incoming request: unsupported funct3 encodings and, optionally, misalignment.
    always_comb begin
        req_illegal  = 1'b0;
        req_misalign = 1'b0;
        if (bus.req_write) begin
            req_illegal = !(bus.req_funct3 == 3'b000 || bus.req_funct3 == 3'b001 ||
                            bus.req_funct3 == 3'b010);
        end else begin
            req_illegal = (bus.req_funct3 == 3'b011 || bus.req_funct3 == 3'b110 ||
                           bus.req_funct3 == 3'b111);
        end
`ifdef MISALIGN_TRAP_EN
        if (bus.req_funct3[1:0] == 2'b01) begin
            req_misalign = bus.req_addr[0];
        end else if (bus.req_funct3[1:0] == 2'b10) begin
            req_misalign = (bus.req_addr[1:0] != 2'b00);
        end
`endif
    end

    // Pick the addressed lane from the BRAM word and extend it to 32 bits.
    // Halfwords look only at addr[1] and words ignore addr[1:0], which is what
    // forces misaligned accesses onto an aligned lane when they are not trapped.
    always_comb begin
        load_byte = mem_rdata_i[{addr_q[1:0], 3'b000} +: 8];
        load_half = addr_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        case (funct3_q)
            3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
            3'b100:  load_data = {24'd0, load_byte};
            3'b001:  load_data = {{16{load_half[15]}}, load_half};
            3'b101:  load_data = {16'd0, load_half};
            default: load_data = mem_rdata_i;
        endcase
    end

    // Next-state logic for the request sequencer and response registers.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        funct3_d = funct3_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        error_d  = error_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    addr_d   = bus.req_addr[AW-1:0];
                    funct3_d = bus.req_funct3;
                    wdata_d  = bus.req_wdata;
                    rdata_d  = 32'd0;
                    error_d  = 1'b0;
                    if (req_illegal || req_misalign) begin
                        error_d = 1'b1;
                        state_d = ST_DONE;
                    end else if (bus.req_write) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_WRITE: state_d = ST_DONE;
            ST_READ:  state_d = ST_WAIT;
            ST_WAIT: begin
                rdata_d = load_data;
                state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State and response registers; synchronous active-low reset clears everything.
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            funct3_q <= 3'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            funct3_q <= funct3_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            error_q  <= error_d;
        end
    end

    // Replicate store data across lanes; the byte mask selects what lands.
    always_comb begin
        case (funct3_q[1:0])
            2'b00:   mem_wdata_o = {4{wdata_q[7:0]}};
            2'b01:   mem_wdata_o = {2{wdata_q[15:0]}};
            default: mem_wdata_o = wdata_q;
        endcase
    end

    // Memory strobes; gated by reset so an aborted store never reaches the BRAM.
    always_comb begin
        mem_wmask_o = 4'b0000;
        mem_rstrb_o = 1'b0;
        if (reset_i && state_q == ST_WRITE) begin
            case (funct3_q[1:0])
                2'b00:   mem_wmask_o = 4'b0001 << addr_q[1:0];
                2'b01:   mem_wmask_o = addr_q[1] ? 4'b1100 : 4'b0011;
                default: mem_wmask_o = 4'b1111;
            endcase
        end
        if (reset_i && state_q == ST_READ) begin
            mem_rstrb_o = 1'b1;
        end
    end

    assign mem_addr_o    = addr_q[AW-1:2];
    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = (state_q == ST_DONE);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_error = error_q;

endmodule
